// File: rtl/mdio_link_monitor.sv
`default_nettype none
// ============================================================================
// Module      : mdio_link_monitor
// Description : Clause-22 PHY bring-up and link poller. After a startup delay
//               it issues up to four init writes, then periodically reads
//               BMSR (reg 1) and reports link status. The optional read
//               response watchdog is enabled by defining MDIO_LINK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_link_monitor #(
    parameter logic [4:0]  PHY_ADDR      = 5'd0,
    parameter logic [23:0] STARTUP_DELAY = 24'd1250000,
    parameter int          INIT_COUNT    = 2,
    parameter logic [4:0]  INIT_REG0     = 5'd0,
    parameter logic [4:0]  INIT_REG1     = 5'd0,
    parameter logic [4:0]  INIT_REG2     = 5'd0,
    parameter logic [4:0]  INIT_REG3     = 5'd0,
    parameter logic [15:0] INIT_DATA0    = 16'h1140,
    parameter logic [15:0] INIT_DATA1    = 16'h1140,
    parameter logic [15:0] INIT_DATA2    = 16'h1140,
    parameter logic [15:0] INIT_DATA3    = 16'h1140,
    parameter logic [23:0] POLL_INTERVAL = 24'd12500000,
    parameter logic [15:0] TIMEOUT       = 16'd4096
) (
    input  logic        clk125,
    input  logic        reset_n,
    output logic [4:0]  cmd_phy_addr,
    output logic [4:0]  cmd_reg_addr,
    output logic [15:0] cmd_data,
    output logic [1:0]  cmd_opcode,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic [15:0] data_out,
    input  logic        data_out_valid,
    output logic        data_out_ready,
    output logic        init_done,
    output logic        link_up,
    output logic [15:0] phy_status,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_DELAY     = 3'd0,
        S_INIT      = 3'd1,
        S_POLL_WAIT = 3'd2,
        S_READ_CMD  = 3'd3,
        S_READ_RESP = 3'd4
    } state_t;

    localparam logic [23:0] c_delay_load = (STARTUP_DELAY == 24'd0) ? 24'd0 : STARTUP_DELAY - 24'd1;
    localparam logic [23:0] c_poll_load  = (POLL_INTERVAL == 24'd0) ? 24'd0 : POLL_INTERVAL - 24'd1;
    localparam logic [1:0]  c_last_idx   = (INIT_COUNT > 1) ? 2'(INIT_COUNT - 1) : 2'd0;
    localparam bit          c_skip_init  = (INIT_COUNT <= 0);

    state_t      r_state, w_state_nxt;
    logic [23:0] r_cnt, w_cnt_nxt;
    logic        r_armed, w_armed_nxt;
    logic [1:0]  r_idx, w_idx_nxt;
    logic        r_init_done, w_init_done_nxt;
    logic        r_link_up, w_link_up_nxt;
    logic [15:0] r_phy_status, w_phy_status_nxt;
    logic [23:0] w_delay_cnt;
    logic [4:0]  w_init_reg;
    logic [15:0] w_init_data;
    logic        w_cmd_fire;

`ifdef MDIO_LINK_TIMEOUT_EN
    localparam logic [15:0] c_tmo_last = (TIMEOUT == 16'd0) ? 16'd0 : TIMEOUT - 16'd1;
    logic [15:0] r_tmo_cnt, w_tmo_cnt_nxt;
    logic        r_timeout_err, w_timeout_err_nxt;
    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign timeout_err      = 1'b0;
`endif

    // The delay counter is 0 out of reset, so its first cycle acts as if N-1 were loaded.
    assign w_delay_cnt = r_armed ? r_cnt : c_delay_load;
    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign init_done   = r_init_done;
    assign link_up     = r_link_up;
    assign phy_status  = r_phy_status;

    always_comb begin
        w_init_reg  = INIT_REG0;
        w_init_data = INIT_DATA0;
        case (r_idx)
            2'd1:    begin w_init_reg = INIT_REG1; w_init_data = INIT_DATA1; end
            2'd2:    begin w_init_reg = INIT_REG2; w_init_data = INIT_DATA2; end
            2'd3:    begin w_init_reg = INIT_REG3; w_init_data = INIT_DATA3; end
            default: begin w_init_reg = INIT_REG0; w_init_data = INIT_DATA0; end
        endcase
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_armed_nxt       = r_armed;
        w_idx_nxt         = r_idx;
        w_init_done_nxt   = r_init_done;
        w_link_up_nxt     = r_link_up;
        w_phy_status_nxt  = r_phy_status;
`ifdef MDIO_LINK_TIMEOUT_EN
        w_tmo_cnt_nxt     = r_tmo_cnt;
        w_timeout_err_nxt = r_timeout_err;
`endif
        cmd_valid      = 1'b0;
        cmd_phy_addr   = 5'd0;
        cmd_reg_addr   = 5'd0;
        cmd_data       = 16'd0;
        cmd_opcode     = 2'b00;
        data_out_ready = 1'b0;

        case (r_state)
            S_DELAY: begin
                w_armed_nxt = 1'b1;
                if (w_delay_cnt == 24'd0) begin
                    w_cnt_nxt = c_skip_init ? c_poll_load : 24'd0;
                    w_idx_nxt = 2'd0;
                    w_state_nxt = c_skip_init ? S_POLL_WAIT : S_INIT;
                end else begin
                    w_cnt_nxt = w_delay_cnt - 24'd1;
                end
            end
            S_INIT: begin
                cmd_valid    = 1'b1;
                cmd_phy_addr = PHY_ADDR;
                cmd_reg_addr = w_init_reg;
                cmd_data     = w_init_data;
                cmd_opcode   = 2'b01;
                if (w_cmd_fire) begin
                    if (r_idx == c_last_idx) begin
                        w_init_done_nxt = 1'b1;
                        w_cnt_nxt       = c_poll_load;
                        w_state_nxt     = S_POLL_WAIT;
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                    end
                end
            end
            S_POLL_WAIT: begin
                if (r_cnt == 24'd0) begin
                    w_state_nxt = S_READ_CMD;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            S_READ_CMD: begin
                cmd_valid    = 1'b1;
                cmd_phy_addr = PHY_ADDR;
                cmd_reg_addr = 5'd1;
                cmd_opcode   = 2'b10;
                if (w_cmd_fire) begin
`ifdef MDIO_LINK_TIMEOUT_EN
                    w_tmo_cnt_nxt = 16'd0;
`endif
                    w_state_nxt = S_READ_RESP;
                end
            end
            S_READ_RESP: begin
                data_out_ready = 1'b1;
                if (data_out_valid) begin
                    w_phy_status_nxt = data_out;
                    w_link_up_nxt    = data_out[2];
                    w_cnt_nxt        = c_poll_load;
                    w_state_nxt      = S_POLL_WAIT;
                end
`ifdef MDIO_LINK_TIMEOUT_EN
                else if (r_tmo_cnt == c_tmo_last) begin
                    w_timeout_err_nxt = 1'b1;
                    w_link_up_nxt     = 1'b0;
                    w_cnt_nxt         = c_poll_load;
                    w_state_nxt       = S_POLL_WAIT;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
                end
`endif
            end
            default: w_state_nxt = S_DELAY;
        endcase
    end

    always_ff @(posedge clk125 or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_DELAY;
            r_cnt         <= 24'd0;
            r_armed       <= 1'b0;
            r_idx         <= 2'd0;
            r_init_done   <= 1'b0;
            r_link_up     <= 1'b0;
            r_phy_status  <= 16'h0000;
`ifdef MDIO_LINK_TIMEOUT_EN
            r_tmo_cnt     <= 16'd0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_armed       <= w_armed_nxt;
            r_idx         <= w_idx_nxt;
            r_init_done   <= w_init_done_nxt;
            r_link_up     <= w_link_up_nxt;
            r_phy_status  <= w_phy_status_nxt;
`ifdef MDIO_LINK_TIMEOUT_EN
            r_tmo_cnt     <= w_tmo_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdio_link_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdio_link_monitor
// Description : Scoreboard bench for mdio_link_monitor: expected commands and
//               status captures are queued by stimulus and popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_link_monitor;

    localparam logic [4:0] PHY = 5'd3;

    typedef struct packed {
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] data;
        logic [1:0]  op;
    } cmd_t;

    logic        clk125 = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_data;
    logic [1:0]  cmd_opcode;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        init_done;
    logic        link_up;
    logic [15:0] phy_status;
    logic        timeout_err;

    mdio_link_monitor #(
        .PHY_ADDR(PHY), .STARTUP_DELAY(24'd10), .INIT_COUNT(2),
        .INIT_REG0(5'd0), .INIT_REG1(5'd1), .INIT_REG2(5'd0), .INIT_REG3(5'd0),
        .INIT_DATA0(16'h1140), .INIT_DATA1(16'h1140), .INIT_DATA2(16'h1140), .INIT_DATA3(16'h1140),
        .POLL_INTERVAL(24'd8), .TIMEOUT(16'd16)
    ) dut (
        .clk125(clk125), .reset_n(reset_n),
        .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data),
        .cmd_opcode(cmd_opcode), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .init_done(init_done), .link_up(link_up), .phy_status(phy_status), .timeout_err(timeout_err)
    );

    always #5 clk125 = ~clk125;

    cmd_t        cur_cmd;
    logic [48:0] all_outs;
    assign cur_cmd  = {cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_opcode};
    assign all_outs = {cmd_valid, data_out_ready, init_done, link_up, timeout_err,
                       phy_status, cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_opcode};

    cmd_t        exp_cmd[$];
    logic [16:0] exp_stat[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: values read in the posedge active region are the pre-edge ones.
    initial begin
        cmd_t got;
        logic cf, rf;
        forever begin
            @(posedge clk125);
            cf  = reset_n && cmd_valid && cmd_ready;
            rf  = reset_n && data_out_valid && data_out_ready;
            got = cur_cmd;
            if (cf) begin
                if (exp_cmd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmd_unexpected: got %0h expected none", got);
                end else begin
                    check("cmd_fields", 64'(got), 64'(exp_cmd.pop_front()));
                end
            end
            if (rf) begin
                #1;
                if (exp_stat.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL status_unexpected: got %0h expected none", {link_up, phy_status});
                end else begin
                    check("status_capture", 64'({link_up, phy_status}), 64'(exp_stat.pop_front()));
                end
            end
        end
    end

    task automatic wait_valid(output int n);
        n = 0;
        do begin @(negedge clk125); n++; end while (!cmd_valid && n < 100);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin @(negedge clk125); n++; end while (!data_out_ready && n < 100);
    endtask

    task automatic respond(input logic [15:0] d);
        exp_stat.push_back({d[2], d});
        data_out       = d;
        data_out_valid = 1'b1;
        @(negedge clk125);
        data_out_valid = 1'b0;
        check("ready_drops", 64'(data_out_ready), 64'd0);
    endtask

    initial begin
        cmd_t w0, w1, rd;
        int n;
        w0 = {PHY, 5'd0, 16'h1140, 2'b01};
        w1 = {PHY, 5'd1, 16'h1140, 2'b01};
        rd = {PHY, 5'd1, 16'h0000, 2'b10};
        cmd_ready = 1'b1; data_out_valid = 1'b0; data_out = 16'h0;

        repeat (3) @(negedge clk125);
        check("reset_outputs", 64'(all_outs), 64'd0);
        exp_cmd.push_back(w0);
        exp_cmd.push_back(w1);
        reset_n = 1'b1;
        wait_valid(n);
        check("startup_latency", 64'(n), 64'd10);
        @(negedge clk125);
        check("init_done_before_last", 64'(init_done), 64'd0);
        @(negedge clk125);
        check("init_done_after_last", 64'({init_done, cmd_valid}), 64'b10);

        exp_cmd.push_back(rd);
        wait_ready(n);
        check("first_read_latency", 64'(n), 64'd9);
        respond(16'h796D);

        // Stray read data while idle must not disturb the captured status.
        data_out = 16'hFFFF; data_out_valid = 1'b1;
        repeat (3) @(negedge clk125);
        data_out_valid = 1'b0;
        check("spurious_ignored", 64'({link_up, phy_status}), 64'({1'b1, 16'h796D}));

        exp_cmd.push_back(rd);
        wait_ready(n);
        respond(16'h7969);
        check("link_down", 64'(link_up), 64'd0);

        exp_cmd.push_back(rd);
        wait_ready(n);
`ifdef MDIO_LINK_TIMEOUT_EN
        n = 0;
        while (data_out_ready && n < 40) begin @(negedge clk125); n++; end
        check("timeout_cycles", 64'(n), 64'd16);
        check("timeout_flags", 64'({timeout_err, link_up, phy_status}), 64'({1'b1, 1'b0, 16'h7969}));
        exp_cmd.push_back(rd);
        wait_valid(n);
        check("repoll_after_timeout", 64'(n), 64'd8);
        wait_ready(n);
        respond(16'h796D);
        check("timeout_sticky", 64'({timeout_err, link_up}), 64'b11);
`else
        repeat (40) @(negedge clk125);
        check("resp_waits", 64'({data_out_ready, timeout_err}), 64'b10);
        respond(16'h796D);
`endif

        // Second run: back-pressure on the first init write, then reset mid-init.
        reset_n = 1'b0; cmd_ready = 1'b0;
        exp_cmd.delete(); exp_stat.delete();
        @(negedge clk125);
        check("reset2_outputs", 64'(all_outs), 64'd0);
        exp_cmd.push_back(w0);
        reset_n = 1'b1;
        wait_valid(n);
        check("startup_latency_2", 64'(n), 64'd10);
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", 64'({cmd_valid, cur_cmd}), 64'({1'b1, w0}));
            if (i < 4) @(negedge clk125);
        end
        exp_cmd.push_back(w1);
        cmd_ready = 1'b1;
        @(negedge clk125);
        cmd_ready = 1'b0;
        check("single_transfer", 64'({cmd_valid, cur_cmd}), 64'({1'b1, w1}));

        #2 reset_n = 1'b0;
        #1 check("async_reset", 64'(all_outs), 64'd0);
        exp_cmd.delete();
        @(negedge clk125);
        exp_cmd.push_back(w0);
        exp_cmd.push_back(w1);
        exp_cmd.push_back(rd);
        cmd_ready = 1'b1;
        reset_n = 1'b1;
        wait_valid(n);
        check("restart_latency", 64'(n), 64'd10);
        repeat (2) @(negedge clk125);
        check("restart_init_done", 64'(init_done), 64'd1);
        wait_ready(n);
        respond(16'h0004);
        repeat (2) @(negedge clk125);
        check("queues_drained", 64'(exp_cmd.size() + exp_stat.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
